// File: rtl/cpu_defs.sv
// Shared CPU definitions: CSR addresses, basic word types, CSR register layouts,
// software write masks and small helpers used by the CSR file.
package cpu_defs;

  typedef logic [13:0] csr_addr_t;
  typedef logic [31:0] u32_t;

  localparam csr_addr_t CSR_CRMD   = 14'h000;
  localparam csr_addr_t CSR_PRMD   = 14'h001;
  localparam csr_addr_t CSR_ECFG   = 14'h004;
  localparam csr_addr_t CSR_ESTAT  = 14'h005;
  localparam csr_addr_t CSR_ERA    = 14'h006;
  localparam csr_addr_t CSR_EENTRY = 14'h00C;
  localparam csr_addr_t CSR_SAVE0  = 14'h030;
  localparam csr_addr_t CSR_SAVE1  = 14'h031;
  localparam csr_addr_t CSR_SAVE2  = 14'h032;
  localparam csr_addr_t CSR_SAVE3  = 14'h033;
  localparam csr_addr_t CSR_TID    = 14'h040;
  localparam csr_addr_t CSR_TCFG   = 14'h041;
  localparam csr_addr_t CSR_TVAL   = 14'h042;
  localparam csr_addr_t CSR_TICLR  = 14'h044;

  // Bits software may change; everything outside a mask is hardware-owned or zero.
  localparam u32_t MASK_CRMD   = 32'h0000_01FF;
  localparam u32_t MASK_PRMD   = 32'h0000_0007;
  localparam u32_t MASK_ECFG   = 32'h0000_1BFF;
  localparam u32_t MASK_ESTAT  = 32'h0000_0003;
  localparam u32_t MASK_EENTRY = 32'hFFFF_FFC0;
  localparam u32_t MASK_FULL   = 32'hFFFF_FFFF;
  localparam u32_t MASK_NONE   = 32'h0000_0000;

  localparam u32_t CRMD_RESET  = 32'h0000_0008;

  typedef struct packed {
    logic [22:0] rsv;
    logic [1:0]  datm;
    logic [1:0]  datf;
    logic        pg;
    logic        da;
    logic        ie;
    logic [1:0]  plv;
  } crmd_t;

  typedef struct packed {
    logic [28:0] rsv;
    logic        pie;
    logic [1:0]  pplv;
  } prmd_t;

  typedef struct packed {
    logic        rsv31;
    logic [8:0]  esubcode;
    logic [5:0]  ecode;
    logic [2:0]  rsv13;
    logic [12:0] is;
  } estat_t;

  typedef struct packed {
    logic [29:0] initval;
    logic        periodic;
    logic        en;
  } tcfg_t;

  function automatic u32_t csr_wmask(input csr_addr_t addr);
    u32_t m;
    case (addr)
      CSR_CRMD:   m = MASK_CRMD;
      CSR_PRMD:   m = MASK_PRMD;
      CSR_ECFG:   m = MASK_ECFG;
      CSR_ESTAT:  m = MASK_ESTAT;
      CSR_EENTRY: m = MASK_EENTRY;
      CSR_ERA, CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3,
      CSR_TID, CSR_TCFG: m = MASK_FULL;
      default:    m = MASK_NONE;
    endcase
    return m;
  endfunction

  function automatic u32_t csr_merge(input u32_t old_v, input u32_t new_v, input u32_t mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// Bus between the core pipeline and the CSR file: write/read ports, exception
// and return commits, interrupt lines and the handler/return PCs.
interface csr_file_if;
  import cpu_defs::*;

  csr_addr_t  csr_addr;
  logic       csr_we;
  u32_t       csr_data;
  csr_addr_t  rd_addr;
  u32_t       rd_data;
  logic       excp_valid;
  logic [5:0] excp_ecode;
  u32_t       excp_pc;
  logic       ertn_valid;
  logic [7:0] hw_int;
  logic       int_pending;
  u32_t       eentry;
  u32_t       era;

  modport master (
    output csr_addr, csr_we, csr_data, rd_addr,
    output excp_valid, excp_ecode, excp_pc, ertn_valid, hw_int,
    input  rd_data, int_pending, eentry, era
  );

  modport slave (
    input  csr_addr, csr_we, csr_data, rd_addr,
    input  excp_valid, excp_ecode, excp_pc, ertn_valid, hw_int,
    output rd_data, int_pending, eentry, era
  );

endinterface

// File: rtl/csr_timer.sv
// Constant timer: loads TVAL on a TCFG write, counts down while enabled, raises a
// one-cycle fire strobe on the edge that reaches zero and optionally reloads.
module csr_timer
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tcfg_we_i,
  input  logic [29:0] tcfg_init_i,
  input  tcfg_t       tcfg_i,
  output u32_t        tval_o,
  output logic        fire_o
);

  u32_t tval_q, tval_d;

  // A TCFG write restarts the count, so it also masks a fire due on that edge.
  assign fire_o = ~tcfg_we_i & tcfg_i.en & (tval_q == 32'd1);
  assign tval_o = tval_q;

  always_comb begin
    tval_d = tval_q;
    if (tcfg_we_i) begin
      tval_d = {tcfg_init_i, 2'b00};
    end else if (tcfg_i.en) begin
      if (tval_q != '0) begin
        tval_d = tval_q - 32'd1;
      end else if (tcfg_i.periodic) begin
        tval_d = {tcfg_i.initval, 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tval_q <= '0;
    end else begin
      tval_q <= tval_d;
    end
  end

endmodule

// File: rtl/csr_file.sv
// CSR file: architectural control/status registers with exception entry and return,
// interrupt-pending generation and a combinational read port with write bypass.
module csr_file
  import cpu_defs::*;
(
  input logic       clk,
  input logic       rst_n,
  csr_file_if.slave bus
);

  crmd_t      crmd_q, crmd_d;
  prmd_t      prmd_q, prmd_d;
  u32_t       ecfg_q, ecfg_d;
  estat_t     estat_q, estat_d;
  u32_t       era_q, era_d;
  u32_t       eentry_q, eentry_d;
  u32_t [3:0] save_q, save_d;
  u32_t       tid_q, tid_d;
  tcfg_t      tcfg_q, tcfg_d;
  u32_t       tval;
  logic       timer_fire;
  logic       wr_en;
  logic       tcfg_we;
  u32_t       rd_raw;
  u32_t       rd_mask;

  // An exception commit squashes any write issued alongside it, bypass included.
  assign wr_en   = bus.csr_we & ~bus.excp_valid;
  assign tcfg_we = wr_en & (bus.csr_addr == CSR_TCFG);

  csr_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .tcfg_we_i   (tcfg_we),
    .tcfg_init_i (bus.csr_data[31:2]),
    .tcfg_i      (tcfg_q),
    .tval_o      (tval),
    .fire_o      (timer_fire)
  );

  always_comb begin
    rd_raw = '0;
    case (bus.rd_addr)
      CSR_CRMD:   rd_raw = u32_t'(crmd_q);
      CSR_PRMD:   rd_raw = u32_t'(prmd_q);
      CSR_ECFG:   rd_raw = ecfg_q;
      CSR_ESTAT:  rd_raw = u32_t'(estat_q);
      CSR_ERA:    rd_raw = era_q;
      CSR_EENTRY: rd_raw = eentry_q;
      CSR_SAVE0:  rd_raw = save_q[0];
      CSR_SAVE1:  rd_raw = save_q[1];
      CSR_SAVE2:  rd_raw = save_q[2];
      CSR_SAVE3:  rd_raw = save_q[3];
      CSR_TID:    rd_raw = tid_q;
      CSR_TCFG:   rd_raw = u32_t'(tcfg_q);
      CSR_TVAL:   rd_raw = tval;
      default:    rd_raw = '0;
    endcase
  end

  // Bypass shows the value the register will hold: hardware bits kept, software bits new.
  assign rd_mask     = csr_wmask(bus.rd_addr);
  assign bus.rd_data = (wr_en && (bus.csr_addr == bus.rd_addr))
                     ? csr_merge(rd_raw, bus.csr_data, rd_mask) : rd_raw;

  assign bus.int_pending = crmd_q.ie & (|(estat_q.is & ecfg_q[12:0]));
  assign bus.eentry      = eentry_q;
  assign bus.era         = era_q;

  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    tid_d    = tid_q;
    tcfg_d   = tcfg_q;

    estat_d.is[9:2] = bus.hw_int;

    if (wr_en) begin
      case (bus.csr_addr)
        CSR_CRMD:   crmd_d   = crmd_t'(csr_merge(crmd_q, bus.csr_data, MASK_CRMD));
        CSR_PRMD:   prmd_d   = prmd_t'(csr_merge(prmd_q, bus.csr_data, MASK_PRMD));
        CSR_ECFG:   ecfg_d   = csr_merge(ecfg_q, bus.csr_data, MASK_ECFG);
        CSR_ESTAT:  estat_d  = estat_t'(csr_merge(estat_d, bus.csr_data, MASK_ESTAT));
        CSR_ERA:    era_d    = bus.csr_data;
        CSR_EENTRY: eentry_d = csr_merge(eentry_q, bus.csr_data, MASK_EENTRY);
        CSR_SAVE0:  save_d[0] = bus.csr_data;
        CSR_SAVE1:  save_d[1] = bus.csr_data;
        CSR_SAVE2:  save_d[2] = bus.csr_data;
        CSR_SAVE3:  save_d[3] = bus.csr_data;
        CSR_TID:    tid_d    = bus.csr_data;
        CSR_TCFG:   tcfg_d   = tcfg_t'(bus.csr_data);
        CSR_TICLR:  if (bus.csr_data[0]) estat_d.is[11] = 1'b0;
        default:    ;
      endcase
    end

    // A fire on the same edge as a TICLR clear must not be lost.
    if (timer_fire) estat_d.is[11] = 1'b1;

    if (bus.excp_valid) begin
      prmd_d.pplv   = crmd_q.plv;
      prmd_d.pie    = crmd_q.ie;
      crmd_d.plv    = 2'b00;
      crmd_d.ie     = 1'b0;
      era_d         = bus.excp_pc;
      estat_d.ecode = bus.excp_ecode;
    end else if (bus.ertn_valid) begin
      crmd_d.plv = prmd_q.pplv;
      crmd_d.ie  = prmd_q.pie;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crmd_q   <= crmd_t'(CRMD_RESET);
      prmd_q   <= '0;
      ecfg_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      eentry_q <= '0;
      save_q   <= '0;
      tid_q    <= '0;
      tcfg_q   <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus pushes expected outputs from an
// address-indexed reference model; a negedge monitor pops and compares.
module tb_csr_file;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst_n;

  csr_file_if bif();

  csr_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        tag;
    bit [31:0] rd;
    bit        ip;
    bit [31:0] era;
    bit [31:0] eentry;
    bit        has_k;
    bit [31:0] k_rd;
    bit        has_kip;
    bit        k_ip;
  } exp_t;

  exp_t      sbq[$];
  exp_t      mon_e;
  int        n_tests = 0;
  int        n_fail  = 0;
  int        tag     = 0;
  bit        k_en    = 0;
  bit [31:0] k_val   = 0;
  bit        kip_en  = 0;
  bit        kip_val = 0;

  bit [31:0] mreg [int];
  int impl  [13] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'hC, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42};
  int alist [18] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'hC, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42,
                     'h44, 'h2, 'h7, 'h45, 'h3FFF};

  function automatic bit [31:0] tb_mask(input int a);
    case (a)
      'h0:  return 32'h0000_01FF;
      'h1:  return 32'h0000_0007;
      'h4:  return 32'h0000_1BFF;
      'h5:  return 32'h0000_0003;
      'hC:  return 32'hFFFF_FFC0;
      'h6, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_reset();
    mreg.delete();
    foreach (impl[i]) mreg[impl[i]] = 32'h0;
    mreg[0] = 32'h8;
  endfunction

  function automatic bit [31:0] m_rd(input int a);
    if (mreg.exists(a)) return mreg[a];
    return 32'h0;
  endfunction

  function automatic void m_edge(input bit rst, input bit we, input int wa, input bit [31:0] wd,
                                 input bit ex, input bit [5:0] ec, input bit [31:0] pc,
                                 input bit er, input bit [7:0] hw);
    bit [31:0] nx [int];
    bit [31:0] crmd, prmd, estat, tcfg, tval, m;
    bit        eff, fire;
    if (!rst) begin
      m_reset();
      return;
    end
    nx   = mreg;
    eff  = we && !ex;
    crmd = m_rd(0);
    prmd = m_rd(1);
    tcfg = m_rd('h41);
    tval = m_rd('h42);
    fire = 1'b0;
    m    = tb_mask(wa);
    if (eff && m != 0) nx[wa] = (m_rd(wa) & ~m) | (wd & m);
    if (eff && wa == 'h41) nx['h42] = wd & 32'hFFFF_FFFC;
    else if (tcfg[0]) begin
      if (tval != 0) begin
        nx['h42] = tval - 1;
        fire = (tval == 1);
      end else if (tcfg[1]) begin
        nx['h42] = tcfg & 32'hFFFF_FFFC;
      end
    end
    estat = nx[5];
    estat[9:2] = hw;
    if (eff && wa == 'h44 && wd[0]) estat[11] = 1'b0;
    if (fire) estat[11] = 1'b1;
    if (ex) begin
      nx[1] = (prmd & ~32'h7) | (crmd & 32'h7);
      nx[0] = crmd & ~32'h7;
      nx[6] = pc;
      estat[21:16] = ec;
    end else if (er) begin
      nx[0] = (nx[0] & ~32'h7) | (prmd & 32'h7);
    end
    nx[5] = estat;
    mreg = nx;
  endfunction

  function automatic void chk(input int tg, input string nm, input bit [31:0] act, input bit [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (tag %0d): actual=%08h required=%08h at %0t", nm, tg, act, req, $time);
    end
  endfunction

  task automatic step(input bit chk_en);
    exp_t      e;
    bit [31:0] ra, m, c0, es, ecf, c_wd, c_pc;
    bit        c_rst, c_we, c_ex, c_er;
    int        c_wa;
    bit [5:0]  c_ec;
    bit [7:0]  c_hw;
    c_rst = rst_n;
    c_we  = bif.csr_we;
    c_wa  = int'(bif.csr_addr);
    c_wd  = bif.csr_data;
    c_ex  = bif.excp_valid;
    c_ec  = bif.excp_ecode;
    c_pc  = bif.excp_pc;
    c_er  = bif.ertn_valid;
    c_hw  = bif.hw_int;
    if (chk_en) begin
      ra = m_rd(int'(bif.rd_addr));
      if (c_we && !c_ex && bif.csr_addr == bif.rd_addr) begin
        m  = tb_mask(int'(bif.rd_addr));
        ra = (ra & ~m) | (c_wd & m);
      end
      c0  = m_rd(0);
      es  = m_rd(5);
      ecf = m_rd(4);
      e.tag     = tag;
      e.rd      = ra;
      e.ip      = c0[2] && ((es[12:0] & ecf[12:0]) != 0);
      e.era     = m_rd(6);
      e.eentry  = m_rd('hC);
      e.has_k   = k_en;
      e.k_rd    = k_val;
      e.has_kip = kip_en;
      e.k_ip    = kip_val;
      sbq.push_back(e);
    end
    k_en   = 1'b0;
    kip_en = 1'b0;
    @(posedge clk);
    m_edge(c_rst, c_we, c_wa, c_wd, c_ex, c_ec, c_pc, c_er, c_hw);
    #1;
  endtask

  task automatic idle();
    rst_n          = 1'b1;
    bif.csr_we     = 1'b0;
    bif.csr_addr   = '0;
    bif.csr_data   = '0;
    bif.rd_addr    = '0;
    bif.excp_valid = 1'b0;
    bif.excp_ecode = '0;
    bif.excp_pc    = '0;
    bif.ertn_valid = 1'b0;
    bif.hw_int     = '0;
  endtask

  task automatic wr(input int a, input bit [31:0] d);
    bif.csr_we   = 1'b1;
    bif.csr_addr = 14'(a);
    bif.csr_data = d;
  endtask

  task automatic kx(input int a, input bit [31:0] v);
    bif.rd_addr = 14'(a);
    k_en  = 1'b1;
    k_val = v;
  endtask

  task automatic kip(input bit v);
    kip_en  = 1'b1;
    kip_val = v;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk(mon_e.tag, "rd_data", bif.rd_data, mon_e.rd);
      chk(mon_e.tag, "int_pending", {31'b0, bif.int_pending}, {31'b0, mon_e.ip});
      chk(mon_e.tag, "era", bif.era, mon_e.era);
      chk(mon_e.tag, "eentry", bif.eentry, mon_e.eentry);
      if (mon_e.has_k) chk(mon_e.tag, "rd_data_fixed", bif.rd_data, mon_e.k_rd);
      if (mon_e.has_kip) chk(mon_e.tag, "int_pending_fixed", {31'b0, bif.int_pending}, {31'b0, mon_e.k_ip});
    end
  end

  initial begin
    #150000;
    $display("FAIL watchdog: actual=timeout required=finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    m_reset();
    idle();
    rst_n = 1'b0;
    step(0);
    step(0);
    rst_n = 1'b1;

    // Reset values
    tag = 1;
    kx('h0, 32'h8);  step(1);
    kx('h42, 32'h0); step(1);

    // Same-cycle bypass, then persistence
    tag = 2;
    wr('h30, 32'hDEADBEEF);
    kx('h30, 32'hDEADBEEF); step(1);
    bif.csr_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kx('h30, 32'hDEADBEEF); step(1);
    end

    // Exception entry and return
    tag = 3;
    wr('h0, 32'h7); step(1);
    bif.csr_we = 1'b0;
    bif.excp_valid = 1'b1; bif.excp_ecode = 6'h0B; bif.excp_pc = 32'h1C00_0100;
    step(1);
    bif.excp_valid = 1'b0;
    kx('h0, 32'h0);          step(1);
    kx('h1, 32'h7);          step(1);
    kx('h6, 32'h1C00_0100);  step(1);
    kx('h5, 32'h000B_0000);  step(1);
    bif.ertn_valid = 1'b1;   step(1);
    bif.ertn_valid = 1'b0;
    kx('h0, 32'h7);          step(1);

    // Periodic timer: fire 8 cycles after load, reload on the next edge
    tag = 4;
    do_reset();
    wr('h41, 32'h0000_000B); step(1);
    bif.csr_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) kx('h5, 32'h0000_0800);
      else if (k == 9) kx('h42, 32'h8);
      else kx('h42, 32'(8 - k));
      step(1);
    end

    // Timer interrupt and TICLR
    tag = 5;
    do_reset();
    wr('h4, 32'h800);  step(1);
    wr('h0, 32'h4);    step(1);
    wr('h41, 32'h5);   step(1);
    bif.csr_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      kip(1'b0); step(1);
    end
    kip(1'b1); step(1);
    wr('h44, 32'h1); kip(1'b1); step(1);
    bif.csr_we = 1'b0;
    kip(1'b0); step(1);
    kip(1'b0); step(1);

    // Write squashed by exception; reset during countdown
    tag = 6;
    do_reset();
    wr('h31, 32'h1234_5678); step(1);
    wr('h31, 32'hAAAA_5555);
    bif.excp_valid = 1'b1; bif.excp_pc = 32'h1C00_0200;
    kx('h31, 32'h1234_5678); step(1);
    bif.excp_valid = 1'b0; bif.csr_we = 1'b0;
    kx('h31, 32'h1234_5678); step(1);
    wr('h41, 32'h0000_0101); step(1);
    bif.csr_we = 1'b0;
    for (int k = 0; k < 3; k++) step(1);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1;
    kx('h42, 32'h0); step(1);
    kx('h41, 32'h0); step(1);

    // Randomized traffic against the reference model
    tag = 100;
    for (int i = 0; i < 1500; i++) begin
      int ai, ri;
      ai = int'($urandom_range(0, 17));
      ri = ($urandom_range(0, 2) == 0) ? ai : int'($urandom_range(0, 17));
      rst_n        = ($urandom_range(0, 199) != 0);
      bif.csr_we   = ($urandom_range(0, 1) == 1);
      bif.csr_addr = 14'(alist[ai]);
      if (alist[ai] == 'h41) bif.csr_data = ($urandom_range(0, 6) << 2) | $urandom_range(0, 3);
      else bif.csr_data = $urandom;
      bif.rd_addr    = 14'(alist[ri]);
      bif.excp_valid = ($urandom_range(0, 31) == 0);
      bif.excp_ecode = 6'($urandom);
      bif.excp_pc    = $urandom;
      bif.ertn_valid = ($urandom_range(0, 15) == 0);
      bif.hw_int     = 8'($urandom);
      step(1);
    end

    idle();
    @(negedge clk);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 entries left", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
